// File: rtl/pu_output_collector_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pu_output_collector_pkg
// Description : Shared types and constants for the PU output collector.
// Revision    : 1.0 - initial release
// ============================================================================
package pu_output_collector_pkg;

    // PU result width (IEEE-754 single precision)
    localparam int DATA_W = 32;

    // Collector iteration state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Magnitude bits only: +0 and -0 both mask to zero
    localparam logic [DATA_W-1:0] FP_ZERO_MASK = {1'b0, {(DATA_W-1){1'b1}}};

endpackage : pu_output_collector_pkg
`default_nettype wire

// File: rtl/pu_output_collector_tag_delay_line.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tag_delay_line
// Description : LATENCY-deep shift register of {valid, idx} tags that tracks
//               issues through a fixed-latency pipeline stage. A synchronous
//               flush kills every tag in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_delay_line #(
    parameter int LATENCY = 2,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [LATENCY-1:0] r_vld;
    logic [IDX_W-1:0]   r_idx [LATENCY];

    // Shift tags one stage per cycle; flush only clears the valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_idx[s] <= '0;
            end
        end else if (i_flush) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_valid;
            r_idx[0] <= i_idx;
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_idx[s] <= r_idx[s-1];
            end
        end
    end

    assign o_valid = r_vld[LATENCY-1];
    assign o_idx   = r_idx[LATENCY-1];

endmodule : tag_delay_line
`default_nettype wire

// File: rtl/pu_output_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pu_output_collector
// Description : Captures PU activation results into a DEPTH-entry buffer,
//               using a delayed neuron tag to know which entry each PU output
//               belongs to. Signals completion of an iteration and reports
//               the nonzero count for single-winner termination.
// Revision    : 1.0 - initial release
// ============================================================================
module pu_output_collector #(
    parameter int DATA_W  = pu_output_collector_pkg::DATA_W,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [IDX_W-1:0]        in_idx,
    input  logic [DATA_W-1:0]       pu_out,
    output logic [DEPTH*DATA_W-1:0] results,
    output logic                    done,
    input  logic                    ack,
    output logic [IDX_W:0]          nonzero_cnt,
    output logic                    single_winner,
    output logic                    err
);

    import pu_output_collector_pkg::*;

    state_e             r_state;
    state_e             w_state_next;
    logic [DATA_W-1:0]  r_results [DEPTH];
    logic [DEPTH-1:0]   r_mask;
    logic [DEPTH-1:0]   r_nz;
    logic [DEPTH-1:0]   w_mask_next;
    logic               r_err;
    logic               w_collect;
    logic               w_tag_vld;
    logic [IDX_W-1:0]   w_tag_idx;
    logic               w_in_range;
    logic               w_write;
    logic               w_drop_err;
    logic               w_pu_nz;
    logic [IDX_W:0]     w_nz_cnt;

    assign w_collect = (r_state == COLLECT);

    // Tag follows the PU pipeline; start flushes anything still in flight
    tag_delay_line #(
        .LATENCY (LATENCY),
        .IDX_W   (IDX_W)
    ) u_tag_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (start),
        .i_valid (in_valid && w_collect),
        .i_idx   (in_idx),
        .o_valid (w_tag_vld),
        .o_idx   (w_tag_idx)
    );

    // Index range check is only meaningful when DEPTH is not a power of two
    generate
        if ((1 << IDX_W) == DEPTH) begin : g_range_full
            assign w_in_range = 1'b1;
        end else begin : g_range_chk
            assign w_in_range = (int'(w_tag_idx) < DEPTH);
        end
    endgenerate

    assign w_pu_nz    = ((pu_out & FP_ZERO_MASK) != '0);
    assign w_write    = w_tag_vld && w_collect && w_in_range && !start;
    assign w_drop_err = !start &&
                        ((in_valid && !w_collect) ||
                         (w_tag_vld && !(w_collect && w_in_range)));

    // Mask as it will be after this edge, so DONE lands on the final write
    always_comb begin
        w_mask_next = r_mask;
        if (w_write) begin
            w_mask_next[w_tag_idx] = 1'b1;
        end
    end

    // Next-state decode; start restarts the iteration from any state
    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = COLLECT;
        end else begin
            case (r_state)
                IDLE:    w_state_next = IDLE;
                COLLECT: if (&w_mask_next) w_state_next = DONE;
                DONE:    if (ack) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Result buffer, written mask, nonzero flags and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_results[i] <= '0;
            end
            r_mask <= '0;
            r_nz   <= '0;
            r_err  <= 1'b0;
        end else if (start) begin
            r_mask <= '0;
            r_nz   <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_write) begin
                r_results[w_tag_idx] <= pu_out;
                r_nz[w_tag_idx]      <= w_pu_nz;
            end
            r_mask <= w_mask_next;
            if (w_drop_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Popcount of nonzero flags
    always_comb begin
        w_nz_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_nz_cnt = w_nz_cnt + (IDX_W+1)'(r_nz[i]);
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_flat
            assign results[g*DATA_W +: DATA_W] = r_results[g];
        end
    endgenerate

    assign done          = (r_state == DONE);
    assign nonzero_cnt   = w_nz_cnt;
    assign single_winner = done && (w_nz_cnt == (IDX_W+1)'(1));
    assign err           = r_err;

endmodule : pu_output_collector
`default_nettype wire

// File: tb/tb_pu_output_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pu_output_collector
// Description : Testbench for pu_output_collector: directed scenarios then
//               random traffic against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pu_output_collector;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int IW    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  in_valid;
    logic [IW-1:0]         in_idx;
    logic [DW-1:0]         pu_out;
    logic [DEPTH*DW-1:0]   results;
    logic                  done;
    logic                  ack;
    logic [IW:0]           nonzero_cnt;
    logic                  single_winner;
    logic                  err;

    pu_output_collector #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .LATENCY (LAT),
        .IDX_W   (IW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_idx        (in_idx),
        .pu_out        (pu_out),
        .results       (results),
        .done          (done),
        .ack           (ack),
        .nonzero_cnt   (nonzero_cnt),
        .single_winner (single_winner),
        .err           (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: iteration phase, buffer contents, and a timing wheel
    // of issues due to come back from the PU.
    int          m_mode;              // 0 idle, 1 collecting, 2 complete
    logic [31:0] m_res [DEPTH];
    bit          m_wr  [DEPTH];
    bit          m_nz  [DEPTH];
    bit          m_err;
    bit          fl_v   [4];
    logic [1:0]  fl_idx [4];
    logic [31:0] pu_pipe [LAT];
    int          cur;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_nz[i]);
        return n;
    endfunction

    function automatic logic [31:0] res_of(input int i);
        return results[i*DW +: DW];
    endfunction

    task automatic m_reset();
        m_mode = 0;
        m_err  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            m_res[i] = '0;
            m_wr[i]  = 1'b0;
            m_nz[i]  = 1'b0;
        end
        for (int i = 0; i < 4; i++) fl_v[i] = 1'b0;
    endtask

    task automatic check_all();
        chk("done", {63'd0, done}, {63'd0, (m_mode == 2)});
        chk("single_winner", {63'd0, single_winner}, {63'd0, (m_mode == 2 && m_count() == 1)});
        chk("nonzero_cnt", 64'(nonzero_cnt), 64'(m_count()));
        chk("err", {63'd0, err}, {63'd0, m_err});
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("results[%0d]", i), 64'(res_of(i)), 64'(m_res[i]));
        end
    endtask

    // One clock cycle: apply inputs, advance the model, then check outputs
    task automatic cyc(input bit v, input logic [1:0] idx, input logic [31:0] val,
                       input bit st, input bit ak);
        int  slot;
        bit  arr;
        bit  all_wr;
        logic [1:0] aidx;
        in_valid = v;
        in_idx   = idx;
        start    = st;
        ack      = ak;
        pu_out   = pu_pipe[LAT-1];
        slot     = cur % 4;
        arr      = fl_v[slot];
        aidx     = fl_idx[slot];
        fl_v[slot] = 1'b0;
        if (st) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_wr[i] = 1'b0;
                m_nz[i] = 1'b0;
            end
            for (int i = 0; i < 4; i++) fl_v[i] = 1'b0;
            m_err  = 1'b0;
            m_mode = 1;
        end else begin
            if (arr) begin
                if (m_mode == 1) begin
                    m_res[aidx] = pu_out;
                    m_wr[aidx]  = 1'b1;
                    m_nz[aidx]  = (pu_out[30:0] != 31'd0);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (v) begin
                if (m_mode == 1) begin
                    fl_v[(cur + LAT) % 4]   = 1'b1;
                    fl_idx[(cur + LAT) % 4] = idx;
                end else begin
                    m_err = 1'b1;
                end
            end
            all_wr = 1'b1;
            for (int i = 0; i < DEPTH; i++) all_wr &= m_wr[i];
            if (m_mode == 1 && all_wr) m_mode = 2;
            else if (m_mode == 2 && ak) m_mode = 0;
        end
        @(posedge clk);
        #1;
        cur++;
        for (int s = LAT - 1; s > 0; s--) pu_pipe[s] = pu_pipe[s-1];
        pu_pipe[0] = val;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, $urandom, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] rv;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_idx   = '0;
        ack      = 1'b0;
        pu_out   = '0;
        cur      = 0;
        for (int s = 0; s < LAT; s++) pu_pipe[s] = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Scenario 1: four in-order issues, two nonzero (one of them -0 is zero)
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 2'd0, 32'h3F800000, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 32'h00000000, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 32'h3F000000, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 32'h80000000, 1'b0, 1'b0);
        idle(1);
        chk("s1_done_before_k6", {63'd0, done}, 64'd0);
        idle(1);
        chk("s1_done_at_k6", {63'd0, done}, 64'd1);
        chk("s1_res0", 64'(res_of(0)), 64'h3F800000);
        chk("s1_res1", 64'(res_of(1)), 64'h00000000);
        chk("s1_res2", 64'(res_of(2)), 64'h3F000000);
        chk("s1_res3", 64'(res_of(3)), 64'h80000000);
        chk("s1_cnt", 64'(nonzero_cnt), 64'd2);
        chk("s1_sw", {63'd0, single_winner}, 64'd0);

        // Scenario 2: single nonzero entry, then ack releases done
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 2'd0, 32'h00000000, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 32'h80000000, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 32'h3E4CCCCD, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 32'h00000000, 1'b0, 1'b0);
        idle(2);
        chk("s2_cnt", 64'(nonzero_cnt), 64'd1);
        chk("s2_sw", {63'd0, single_winner}, 64'd1);
        cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        chk("s2_done_after_ack", {63'd0, done}, 64'd0);

        // Scenario 3: duplicate idx 1, last write wins
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 2'd1, 32'h3F800000, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 32'h00000000, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 32'h40000000, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 32'h00000000, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 32'h3F800000, 1'b0, 1'b0);
        chk("s3_not_done_yet", {63'd0, done}, 64'd0);
        idle(2);
        chk("s3_done", {63'd0, done}, 64'd1);
        chk("s3_res1", 64'(res_of(1)), 64'h00000000);
        chk("s3_cnt", 64'(nonzero_cnt), 64'd2);

        // Scenario 4: start while a tag is in flight kills it
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 2'd0, 32'h3F800000, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        idle(3);
        chk("s4_res0_kept", 64'(res_of(0)), 64'h40000000);
        chk("s4_err", {63'd0, err}, 64'd0);
        chk("s4_done", {63'd0, done}, 64'd0);
        chk("s4_cnt", 64'(nonzero_cnt), 64'd0);

        // Scenario 5a: extra tag arrives after completion
        cyc(1'b1, 2'd0, 32'h11111111, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 32'h22222222, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 32'h33333333, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 32'h44444444, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 32'h55555555, 1'b0, 1'b0);
        idle(3);
        chk("s5_err_late_tag", {63'd0, err}, 64'd1);
        chk("s5_res0_unchanged", 64'(res_of(0)), 64'h11111111);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        chk("s5_err_cleared", {63'd0, err}, 64'd0);
        // Scenario 5b: issue while idle
        cyc(1'b1, 2'd0, 32'h66666666, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 32'h77777777, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 32'h88888888, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 32'h99999999, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 2'd2, 32'hAAAAAAAA, 1'b0, 1'b0);
        idle(2);
        chk("s5_err_idle_issue", {63'd0, err}, 64'd1);
        chk("s5_res2_unchanged", 64'(res_of(2)), 64'h88888888);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        chk("s5_err_cleared2", {63'd0, err}, 64'd0);

        // Scenario 6: asynchronous reset mid-collect with tags in flight
        cyc(1'b1, 2'd0, 32'h3F800000, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 32'h40400000, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 32'h40800000, 1'b0, 1'b0);
        in_valid = 1'b0;
        start    = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("s6_done", {63'd0, done}, 64'd0);
        chk("s6_err", {63'd0, err}, 64'd0);
        chk("s6_cnt", 64'(nonzero_cnt), 64'd0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("s6_res%0d", i), 64'(res_of(i)), 64'd0);
        pu_out = 32'h40800000;
        @(posedge clk);
        #1;
        cur++;
        for (int i = 0; i < DEPTH; i++) chk($sformatf("s6_nowrite%0d", i), 64'(res_of(i)), 64'd0);
        rst_n = 1'b1;
        m_reset();
        idle(3);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       rv = 32'h00000000;
                1:       rv = 32'h80000000;
                default: rv = $urandom;
            endcase
            cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rv,
                ($urandom_range(0, 19) == 0) || (m_mode == 0 && $urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pu_output_collector
`default_nettype wire

// File: doc/pu_output_collector.md
Name: pu_output_collector

Overview:
- Downstream neighbour of the 4-input processing unit (PU). The PU is a 2-register pipeline of multiply, adder tree, then activation, with no valid signal of its own.
- This block tracks which neuron index each PU issue belongs to and delays that tag by the PU latency. It captures the activation result into a DEPTH-entry result buffer.
- When every neuron of the current iteration has been written, it raises done and reports how many results are nonzero, for the MaxNet-style single-winner termination check.

Parameters:
DATA_W, 32, width of the PU result (IEEE-754 single)
DEPTH, 4, neurons per iteration (result buffer entries)
LATENCY, 2, PU register stages from input presentation to valid out
IDX_W, $clog2(DEPTH), neuron index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begin a new iteration (clears buffer)
in_valid  input  1  high in the cycle the PU inputs for one neuron are presented
in_idx  input  IDX_W  neuron index of that PU issue
pu_out  input  DATA_W  PU activation output
results  output  DEPTH*DATA_W  flattened buffer; entry i at [i*DATA_W +: DATA_W]
done  output  1  all DEPTH entries written this iteration; held until ack
ack  input  1  consumer has read results; releases done
nonzero_cnt  output  IDX_W+1  number of entries whose pu_out[DATA_W-2:0] != 0
single_winner  output  1  done && nonzero_cnt == 1
err  output  1  sticky: write dropped or issue outside COLLECT; cleared by start

Behaviour:
- Reset: async on rst_n low. State goes to IDLE. results, written mask, nonzero flags, tag pipeline, done and err all go to 0.
- States are IDLE, COLLECT and DONE.
  - IDLE: start moves to COLLECT.
  - COLLECT: when the written mask becomes all ones, move to DONE.
  - DONE: ack moves to IDLE.
  - start in any state clears the mask, nonzero flags, err and tag pipeline, then enters COLLECT. results data is not cleared.
- Tag pipeline: LATENCY stages of {valid, idx}.
  - Stage 0 loads (in_valid && state==COLLECT) at each edge.
  - Issue with in_valid high in cycle k gives a tag at the last stage in cycle k+LATENCY. pu_out is valid in that same cycle.
  - The entry is written at the end of cycle k+LATENCY and is visible on results from cycle k+LATENCY+1.
- Write, when the last-stage tag is valid and state==COLLECT:
  - results[idx] <= pu_out
  - mask[idx] <= 1
  - nz[idx] <= (pu_out[DATA_W-2:0] != 0). Both +0 and -0 count as zero.
- Duplicate index: overwrites the entry and updates its nz flag. The mask does not double count.
- nonzero_cnt: combinational popcount of nz.
- Completion: the transition to DONE happens on the same edge as the final write. done is high from the next cycle.
- in_valid while state != COLLECT: issue dropped, err <= 1.
- Last-stage tag arriving in DONE or IDLE: write dropped, err <= 1.
- Out-of-range idx (>= DEPTH, when DEPTH is not a power of 2): write dropped, err <= 1.
- start and last-stage write in the same cycle: start wins. The write is dropped, no err, and the pipeline is flushed.
- ack outside DONE: ignored.
- Back-to-back issues: one per cycle, full throughput, no stalls.
- done and single_winner are registered or state-decoded. They are glitch-free on state alone.

Decomposition:
- Shared package holds:
  - DATA_W
  - state enum {IDLE, COLLECT, DONE}
  - an FP_ZERO_MASK constant giving the magnitude bits [DATA_W-2:0]
- One natural sub-module, tag_delay_line: a LATENCY-deep shift register of {valid, idx} with a synchronous flush input. It is reusable for any fixed-latency PU stage.
- The popcount stays inline.

Test Plan:
1. Reset, start, then issue idx 0..3 in consecutive cycles with pu_out = 0x3F800000, 0x00000000, 0x3F000000, 0x80000000 at cycles k+2..k+5.
   - Required: results = those values in order.
   - Required: done first high in cycle k+6.
   - Required: nonzero_cnt = 2, single_winner = 0.
2. Same as scenario 1, but only idx 2 is nonzero (0x3E4CCCCD).
   - Required: nonzero_cnt = 1, single_winner = 1.
   - Required: ack drops done next cycle and state returns to IDLE.
3. Issue idx 1 twice: first with 0x3F800000, then 0x00000000, then idx 0, 2 and 3.
   - Required: entry 1 = 0x00000000.
   - Required: done only after all four distinct indices are written; nonzero_cnt excludes entry 1.
4. Issue idx 0, then assert start one cycle later (tag still in flight).
   - Required: no write to entry 0, mask stays empty, err = 0, done stays low.
5. in_valid high while IDLE, and a tag arriving in DONE.
   - Required: err = 1 and results are unchanged.
   - Required: a following start clears err to 0.
6. Drive rst_n low mid-COLLECT, asynchronously between edges.
   - Required: done, err, nonzero_cnt and results go to 0 immediately, and no write occurs at the next edge.
